sram_arb: RTL and testbench
===========================

# sram_arb

Two-port arbiter/sequencer that shares the 4-word by 4-bit `sram_ds` storage between two independent requesters. It sits directly in front of the SRAM. It accepts one read or write per grant, then drives the SRAM enable/write/address/data pins with the cycle sequence the SRAM requires. It returns read data and a completion pulse to the winning requester. Arbitration is round-robin by default.

## Interface
- `ADDR_W`, 2, SRAM address width.
- `DATA_W`, 4, SRAM data width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending; held until the matching done.
- `req0_wr` / `req1_wr`  in  1  1 = write, 0 = read.
- `req0_addr` / `req1_addr`  in  ADDR_W  word address.
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data.
- `req0_done` / `req1_done`  out  1  one-cycle completion strobe.
- `rdata`  out  DATA_W  read data; valid only while a done strobe is high for a read.
- `busy`  out  1  high in any state other than IDLE.
- `sram_en`, `sram_wr`  out  1  SRAM enable and write strobe.
- `sram_addr`  out  ADDR_W;  `sram_wdata`  out  DATA_W.
- `sram_rdata`  in  DATA_W  SRAM read port; may be Z outside reads.

Decided: one clock; reset is asynchronous and active-high, on ports `clk` and `rst`. The integration ties the SRAM's active-low reset to `!rst`.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_DATA.
- IDLE: the FSM samples both valids at each edge.
  - If no valid is high, it stays in IDLE.
  - Otherwise it picks a winner, latches that requester's `wr`, `addr` and `wdata` into `owner`/`op_*` registers, and goes to WR or RD_ADDR.
- Round-robin rule:
  - Only one valid high: that requester wins.
  - Both valids high: the requester not equal to `last_grant` wins.
  - `last_grant` updates on every grant. Its reset value is 1, so req0 wins the first contest.
- WR state:
  - Drives `sram_en`=1, `sram_wr`=1 with the latched address and data.
  - `reqN_done` is high for the owner.
  - Next state is IDLE.
- RD_ADDR state: drives `sram_en`=1, `sram_wr`=0 and the latched address. The SRAM loads its read register at the closing edge. Next state is RD_DATA.
- RD_DATA state:
  - Keeps the same SRAM pins as RD_ADDR.
  - `rdata` = `sram_rdata`, and `reqN_done` is high for the owner.
  - Next state is IDLE.
- Outside RD_DATA, `rdata` = 0. The Z from the SRAM is never forwarded.
- In IDLE all `sram_*` outputs are 0.
- `reqN_done` decodes combinationally from state and owner. The requester samples it at the closing edge and may drop or replace its request in the next cycle.
- A requester whose valid drops before it is granted is simply not granted. The request fields are sampled only at the grant edge, so later changes do not affect the operation in flight.
- Reset (async, any state):
  - State goes to IDLE, `last_grant`=1, `owner`=0, `op_*`=0.
  - All outputs are 0 immediately; `busy`=0.
  - An in-flight operation is dropped with no done.

## Timing
- Write: valid seen at edge E0, WR during E0–E1, memory updated at E1. The requester's next request can be granted at E2.
- Read: grant at E0, RD_ADDR E0–E1, RD_DATA E1–E2 with done and rdata, IDLE after E2.
- Minimum spacing is one IDLE cycle between grants.
- Sustained throughput with both requesters always valid: alternating grants, write every 2 cycles, read every 3 cycles.
- No combinational path from any `reqN_*` input to any output.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN`:
  - Defined: req0 always wins when both valids are high, and `last_grant` is not implemented.
  - Undefined (default): round-robin as described above.
  - All other timing is identical in both builds.

## Structure
- Package `sram_arb_pkg`:
  - enum `arb_state_e` (IDLE, WR, RD_ADDR, RD_DATA).
  - Default `ADDR_W`/`DATA_W` constants.
  - Requester index typedef.
- One sub-module, `sram_arb_rr`: a 2-way round-robin/priority picker with a `grant_en` input and a registered `last_grant`. It holds the macro-dependent logic.
- The FSM and SRAM pin drive stay in `sram_arb`.

## Test plan
- Reset, then req0 writes addr 2 data 0xA: `sram_en`=`sram_wr`=1, `sram_addr`=2 and `req0_done` all occur in the same cycle, one cycle after valid. A following req0 read of addr 2 returns `rdata`=0xA with `req0_done` 2 cycles after the grant.
- Both valids held continuously, both writing: grant order is req0, req1, req0, req1. With `SRAM_ARB_FIXED_PRIO_EN` defined, the order is req0 only until req0 drops valid.
- req1 reads addr 3 while req0 writes addr 3 = 0x5 at the same time: req0 is served first, then req1 gets `rdata`=0x5.
- Assert `rst` during RD_ADDR: outputs are 0 immediately, no done, FSM is in IDLE after reset release, and the first contest goes to req0.
- req0 changes `req0_addr` from 1 to 2 during RD_ADDR: the SRAM address stays 1 through RD_DATA.
- Idle with no valids: `busy`=0, all `sram_*`=0, `rdata`=0 for 20 cycles even when `sram_rdata` is driven to Z.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM encoding, default widths and requester index type
// for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } arb_state_e;

    typedef logic req_idx_t;

    // A lone requester always wins; only a tie consults the preference.
    function automatic req_idx_t pick(
        input logic     valid0,
        input logic     valid1,
        input req_idx_t tie
    );
        if (valid0 && valid1) begin
            return tie;
        end
        return valid1 ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// sram_arb_rr: 2-way winner picker with registered last_grant.
// SRAM_ARB_FIXED_PRIO_EN selects fixed req0 priority instead of round-robin.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic grant_en,
    output logic grant
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused;

    assign unused = clk ^ rst ^ grant_en;
    assign grant  = pick(valid0, valid1, 1'b0);
`else
    req_idx_t last_grant;

    // Reset value 1 hands the first contest to req0.
    assign grant = pick(valid0, valid1, ~last_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_en) begin
            last_grant <= grant;
        end
    end
`endif

endmodule

// File: rtl/sram_arb.sv
// sram_arb: shares one small SRAM between two requesters, one access per grant.
// Round-robin by default; SRAM_ARB_FIXED_PRIO_EN gives req0 fixed priority.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req0_done,
    output logic              req1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              sram_en,
    output logic              sram_wr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    arb_state_e        state;
    arb_state_e        state_nx;
    req_idx_t          owner;
    logic              op_wr;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;

    logic              any_valid;
    logic              grant_en;
    req_idx_t          winner;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              done;

    assign any_valid = req0_valid | req1_valid;
    assign grant_en  = (state == IDLE) && any_valid;

    sram_arb_rr u_rr (
        .clk      (clk),
        .rst      (rst),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .grant_en (grant_en),
        .grant    (winner)
    );

    assign sel_wr    = winner ? req1_wr    : req0_wr;
    assign sel_addr  = winner ? req1_addr  : req0_addr;
    assign sel_wdata = winner ? req1_wdata : req0_wdata;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_en) begin
                    state_nx = sel_wr ? WR : RD_ADDR;
                end
            end
            WR:      state_nx = IDLE;
            RD_ADDR: state_nx = RD_DATA;
            RD_DATA: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request fields are captured only here; later changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            op_wr    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
        end else begin
            state <= state_nx;
            if (grant_en) begin
                owner    <= winner;
                op_wr    <= sel_wr;
                op_addr  <= sel_addr;
                op_wdata <= sel_wdata;
            end
        end
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wr    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        rdata      = '0;
        done       = 1'b0;
        unique case (state)
            WR: begin
                sram_en    = 1'b1;
                sram_wr    = op_wr;
                sram_addr  = op_addr;
                sram_wdata = op_wdata;
                done       = 1'b1;
            end
            RD_ADDR: begin
                sram_en   = 1'b1;
                sram_addr = op_addr;
            end
            RD_DATA: begin
                sram_en   = 1'b1;
                sram_addr = op_addr;
                rdata     = sram_rdata;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign req0_done = done & ~owner;
    assign req1_done = done & owner;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a behavioural SRAM.
module tb_sram_arb;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v [2];
    logic       w [2];
    logic [1:0] a [2];
    logic [3:0] d [2];

    logic       req0_done, req1_done, busy, sram_en, sram_wr;
    logic [3:0] rdata, sram_wdata;
    logic [1:0] sram_addr;
    wire  [3:0] sram_rdata;

    logic [3:0] mem [4];
    logic [3:0] rreg;
    logic       roe;
    logic       zmode;
    logic [3:0] junk;

    int n_chk = 0;
    int n_pass = 0;

    sram_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v[0]),
        .req0_wr    (w[0]),
        .req0_addr  (a[0]),
        .req0_wdata (d[0]),
        .req1_valid (v[1]),
        .req1_wr    (w[1]),
        .req1_addr  (a[1]),
        .req1_wdata (d[1]),
        .req0_done  (req0_done),
        .req1_done  (req1_done),
        .rdata      (rdata),
        .busy       (busy),
        .sram_en    (sram_en),
        .sram_wr    (sram_wr),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural SRAM: read register drives the bus only in the cycle after
    // the first read edge; otherwise Z or junk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= 4'h0;
            rreg <= 4'h0;
            roe  <= 1'b0;
        end else begin
            roe <= sram_en && !sram_wr && !roe;
            if (sram_en && sram_wr) mem[sram_addr] <= sram_wdata;
            if (sram_en && !sram_wr) rreg <= mem[sram_addr];
        end
    end

    assign sram_rdata = roe ? rreg : (zmode ? 4'bz : junk);

    function automatic logic [14:0] pins();
        return {busy, sram_en, sram_wr, sram_addr, sram_wdata,
                req0_done, req1_done, rdata};
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        v[0] = 1'b0;
        v[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (pins() !== 15'd0) $display("FAIL reset_pins got=%h exp=0", pins());
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (pins() !== 15'd0) $display("FAIL post_reset_idle got=%h exp=0", pins());
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [10:0] o;
        do_reset();
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 2'd2; d[0] = 4'hA;
        @(posedge clk);
        @(negedge clk);
        o = {busy, sram_en, sram_wr, sram_addr, sram_wdata, req0_done, req1_done};
        n_chk++;
        if (o !== {1'b1, 1'b1, 1'b1, 2'd2, 4'hA, 1'b1, 1'b0})
            $display("FAIL wr_cycle got=%h exp=%h", o,
                     {1'b1, 1'b1, 1'b1, 2'd2, 4'hA, 1'b1, 1'b0});
        else n_pass++;
        @(posedge clk);
        #1;
        w[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({busy, sram_en, req0_done} !== 3'b000)
            $display("FAIL wr_gap got=%b exp=000", {busy, sram_en, req0_done});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({sram_en, sram_wr, sram_addr, req0_done, rdata} !== {1'b1, 1'b0, 2'd2, 1'b0, 4'h0})
            $display("FAIL rd_addr got=%h", {sram_en, sram_wr, sram_addr, req0_done, rdata});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({sram_en, sram_addr, req0_done, req1_done, rdata} !== {1'b1, 2'd2, 1'b1, 1'b0, 4'hA})
            $display("FAIL rd_data got=%h rdata=%h exp_rdata=a",
                     {sram_en, sram_addr, req0_done, req1_done}, rdata);
        else n_pass++;
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rd_end_busy got=%b exp=0", busy);
        else n_pass++;
    endtask

    task automatic test_contest();
        logic [1:0] got;
        logic [1:0] exp;
        do_reset();
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 2'd0; d[0] = 4'h3;
        v[1] = 1'b1; w[1] = 1'b1; a[1] = 2'd1; d[1] = 4'h6;
        for (int i = 0; i < 5; i++) begin
            got = 2'b00;
            for (int t = 0; t < 4 && got == 2'b00; t++) begin
                @(negedge clk);
                got = {req1_done, req0_done};
            end
            if (i == 4) exp = 2'b10;
            else if (FIXED) exp = 2'b01;
            else exp = (i % 2 == 1) ? 2'b10 : 2'b01;
            n_chk++;
            if (got !== exp) $display("FAIL contest_%0d got=%b exp=%b", i, got, exp);
            else n_pass++;
            if (i == 3) begin
                @(posedge clk);
                #1;
                v[0] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_raw();
        logic       found;
        logic [3:0] got;
        do_reset();
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 2'd3; d[0] = 4'h5;
        v[1] = 1'b1; w[1] = 1'b0; a[1] = 2'd3; d[1] = 4'h0;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({req0_done, req1_done, sram_wr, sram_addr} !== {1'b1, 1'b0, 1'b1, 2'd3})
            $display("FAIL raw_first got=%b", {req0_done, req1_done, sram_wr, sram_addr});
        else n_pass++;
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        found = 1'b0;
        got = 4'h0;
        for (int t = 0; t < 5 && !found; t++) begin
            @(negedge clk);
            if (req1_done === 1'b1) begin
                found = 1'b1;
                got = rdata;
            end
        end
        n_chk++;
        if ({found, got} !== {1'b1, 4'h5}) $display("FAIL raw_second got=%b/%h exp=1/5", found, got);
        else n_pass++;
        @(posedge clk);
        #1;
        v[1] = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        v[0] = 1'b1; w[0] = 1'b0; a[0] = 2'd1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy, sram_en, sram_wr, req0_done} !== 4'b1100)
            $display("FAIL pre_rst_rd got=%b exp=1100", {busy, sram_en, sram_wr, req0_done});
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (pins() !== 15'd0) $display("FAIL async_clear got=%h exp=0", pins());
        else n_pass++;
        v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (pins() !== 15'd0) $display("FAIL held_rst got=%h exp=0", pins());
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (pins() !== 15'd0) $display("FAIL released_idle got=%h exp=0", pins());
        else n_pass++;
        @(posedge clk);
        #1;
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 2'd0; d[0] = 4'h1;
        v[1] = 1'b1; w[1] = 1'b1; a[1] = 2'd1; d[1] = 4'h2;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({req0_done, req1_done} !== 2'b10)
            $display("FAIL first_contest got=%b exp=10", {req0_done, req1_done});
        else n_pass++;
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        v[1] = 1'b0;
    endtask

    task automatic test_addr_hold();
        do_reset();
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 2'd1; d[0] = 4'h7;
        @(posedge clk);
        @(posedge clk);
        #1;
        a[0] = 2'd2; d[0] = 4'hC;
        @(posedge clk);
        @(posedge clk);
        #1;
        w[0] = 1'b0; a[0] = 2'd1;
        @(posedge clk);
        #1;
        a[0] = 2'd2;
        @(negedge clk);
        n_chk++;
        if (sram_addr !== 2'd1) $display("FAIL hold_rd_addr got=%0d exp=1", sram_addr);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({sram_addr, req0_done, rdata} !== {2'd1, 1'b1, 4'h7})
            $display("FAIL hold_rd_data got=%0d/%b/%h exp=1/1/7", sram_addr, req0_done, rdata);
        else n_pass++;
        @(posedge clk);
        #1;
        v[0] = 1'b0;
    endtask

    task automatic test_idle_z();
        do_reset();
        zmode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if (pins() !== 15'd0) $display("FAIL idle_z_%0d got=%h exp=0", i, pins());
            else n_pass++;
        end
        zmode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            junk = 4'($urandom);
            @(negedge clk);
            n_chk++;
            if (pins() !== 15'd0) $display("FAIL idle_junk_%0d got=%h exp=0", i, pins());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int          m_busy;
        logic        m_last, m_owner, m_wr, win, mine, eb;
        logic [1:0]  m_addr;
        logic [3:0]  m_wd, m_rd;
        logic [3:0]  m_mem [4];
        logic        done_prev [2];
        logic [14:0] exp_p, obs_p;
        do_reset();
        zmode = 1'b0;
        m_busy = 0; m_last = 1'b1; m_owner = 1'b0; m_wr = 1'b0;
        m_addr = 2'd0; m_wd = 4'h0; m_rd = 4'h0;
        for (int i = 0; i < 4; i++) m_mem[i] = 4'h0;
        done_prev[0] = 1'b0;
        done_prev[1] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            if (m_busy > 0) begin
                m_busy--;
            end else if (v[0] || v[1]) begin
                if (v[0] && v[1]) win = FIXED ? 1'b0 : ~m_last;
                else win = v[1];
                m_last = win; m_owner = win;
                m_wr = w[win]; m_addr = a[win]; m_wd = d[win];
                if (m_wr) begin
                    m_mem[m_addr] = m_wd;
                    m_busy = 1;
                end else begin
                    m_rd = m_mem[m_addr];
                    m_busy = 2;
                end
            end
            #1;
            junk = 4'($urandom);
            for (int r = 0; r < 2; r++) begin
                mine = (m_busy > 0) && (m_owner == r[0]);
                if (done_prev[r] || !v[r]) begin
                    v[r] = ($urandom_range(0, 2) != 0);
                    w[r] = 1'($urandom);
                    a[r] = 2'($urandom);
                    d[r] = 4'($urandom);
                end else if (mine) begin
                    if ($urandom_range(0, 3) == 0) begin
                        w[r] = 1'($urandom);
                        a[r] = 2'($urandom);
                        d[r] = 4'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    v[r] = 1'b0;
                end
            end
            @(negedge clk);
            eb = (m_busy > 0);
            exp_p = {eb, eb, eb && m_wr, eb ? m_addr : 2'd0,
                     (eb && m_wr) ? m_wd : 4'd0,
                     m_busy == 1 && m_owner == 1'b0,
                     m_busy == 1 && m_owner == 1'b1,
                     (m_busy == 1 && !m_wr) ? m_rd : 4'd0};
            obs_p = {busy, sram_en, sram_wr, sram_addr,
                     (eb && !m_wr) ? 4'd0 : sram_wdata,
                     req0_done, req1_done, rdata};
            n_chk++;
            if (obs_p !== exp_p) $display("FAIL rand_%0d got=%h exp=%h", cyc, obs_p, exp_p);
            else n_pass++;
            done_prev[0] = (m_busy == 1) && (m_owner == 1'b0);
            done_prev[1] = (m_busy == 1) && (m_owner == 1'b1);
        end
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        v[1] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        zmode = 1'b1;
        junk = 4'h0;
        for (int r = 0; r < 2; r++) begin
            v[r] = 1'b0; w[r] = 1'b0; a[r] = 2'd0; d[r] = 4'h0;
        end
        test_reset();
        test_write_read();
        test_contest();
        test_raw();
        test_reset_mid_read();
        test_addr_hold();
        test_idle_z();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
